// File: rtl/alu_pipe_nbit.sv
// alu_pipe_nbit: registered, valid/ready handshaked DWIDTH-bit ALU.
//   Sits between register-file read and writeback. Single-cycle ops register
//   result/flags one cycle after accept. A stored carry (cq) chains multi-word
//   ADC/SBB sequences.
// Optional feature macro: ALU_MUL_EN
//   defined   -> mode=1/opsel=111 is an unsigned shift-add multiply (DWIDTH cycles)
//   undefined -> mode=1/opsel=111 is NOR, busy tied low
// Ports:
//   clk, rst (async, active-high)
//   in_valid/in_ready   : request handshake (accept = in_valid & in_ready)
//   op1, op2, opsel, mode, carry_clr : operation request
//   out_valid/out_ready : result handshake (xfer = out_valid & out_ready)
//   result, c_flag, z_flag, o_flag, s_flag : registered result and flags
//   busy                : multiply in progress
module alu_pipe_nbit #(
    parameter int unsigned DWIDTH = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DWIDTH-1:0] op1,
    input  logic [DWIDTH-1:0] op2,
    input  logic [2:0]        opsel,
    input  logic              mode,
    input  logic              carry_clr,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DWIDTH-1:0] result,
    output logic              c_flag,
    output logic              z_flag,
    output logic              o_flag,
    output logic              s_flag,
    output logic              busy
);

    localparam int unsigned W   = DWIDTH;
    localparam int unsigned WP1 = DWIDTH + 1;

    logic [W-1:0] result_q, result_d;
    logic         c_q, c_d, z_q, z_d, o_q, o_d, s_q, s_d;
    logic         out_valid_q, out_valid_d;
    logic         cq_q, cq_d;

    logic         accept;
    logic         take_alu;
    logic         cq_eff;
    logic [W-1:0] add_a, add_b;
    logic         add_cin;
    logic [W:0]   add_sum;
    logic [W-1:0] alu_res;
    logic         alu_c, alu_o;

`ifdef ALU_MUL_EN
    localparam int unsigned CW = $clog2(DWIDTH);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_MUL  = 1'b1
    } state_t;

    state_t         state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [W-1:0]   mcand_q, mcand_d;
    logic [2*W-1:0] prod_q, prod_d;
    logic [W:0]     mul_sum;
    logic [2*W-1:0] prod_step;
    logic           hi_nz;
    logic           is_mul;

    assign is_mul   = mode & (opsel == 3'b111);
    assign in_ready = (state_q == S_IDLE) & (~out_valid_q | out_ready);
    assign busy     = (state_q == S_MUL);

    // One shift-add step: conditionally add multiplicand into the high half, shift right.
    always_comb begin : mul_step
        mul_sum   = {1'b0, prod_q[2*W-1:W]} + (prod_q[0] ? {1'b0, mcand_q} : '0);
        prod_step = {mul_sum, prod_q[W-1:1]};
        hi_nz     = |prod_step[2*W-1:W];
    end
`else
    assign in_ready = ~out_valid_q | out_ready;
    assign busy     = 1'b0;
`endif

    assign accept = in_valid & in_ready;
    // carry_clr takes effect before a same-cycle ADC/SBB reads the stored carry.
    assign cq_eff = cq_q & ~carry_clr;

    // Single-cycle datapath: shared adder for all arithmetic ops plus logic/shift unit.
    always_comb begin : alu_comb
        add_a   = op1;
        add_b   = op2;
        add_cin = 1'b0;
        case (opsel)
            3'b001:  begin add_b = ~op2; add_cin = 1'b1;   end
            3'b010:  begin                add_cin = cq_eff; end
            3'b011:  begin add_b = ~op2; add_cin = cq_eff; end
            3'b100:  begin add_b = '0;   add_cin = 1'b1;   end
            3'b101:  begin add_b = '1;                      end
            3'b110:  begin add_b = '0;                      end
            3'b111:  begin add_a = '0; add_b = ~op1; add_cin = 1'b1; end
            default: ;
        endcase
        add_sum = {1'b0, add_a} + {1'b0, add_b} + WP1'(add_cin);

        alu_res = add_sum[W-1:0];
        alu_c   = add_sum[W];
        // Carry into MSB recovered from the MSB sum bit, XORed with carry out.
        alu_o   = add_a[W-1] ^ add_b[W-1] ^ add_sum[W-1] ^ add_sum[W];

        if (!mode && opsel == 3'b110) begin
            alu_res = op1;
            alu_c   = 1'b0;
            alu_o   = 1'b0;
        end else if (mode) begin
            alu_c = 1'b0;
            alu_o = 1'b0;
            case (opsel)
                3'b000:  alu_res = op1 & op2;
                3'b001:  alu_res = op1 | op2;
                3'b010:  alu_res = op1 ^ op2;
                3'b011:  alu_res = ~op1;
                3'b100:  begin alu_res = {op1[W-2:0], 1'b0};     alu_c = op1[W-1]; end
                3'b101:  begin alu_res = {1'b0, op1[W-1:1]};     alu_c = op1[0];   end
                3'b110:  begin alu_res = {op1[W-1], op1[W-1:1]}; alu_c = op1[0];   end
                default: alu_res = ~(op1 | op2);
            endcase
        end
    end

    // Next-state: output hold/drain, single-cycle load, multiply sequencing.
    always_comb begin : next_comb
        result_d    = result_q;
        c_d         = c_q;
        z_d         = z_q;
        o_d         = o_q;
        s_d         = s_q;
        out_valid_d = out_valid_q & ~out_ready;
        cq_d        = cq_eff;
        take_alu    = accept;
`ifdef ALU_MUL_EN
        state_d     = state_q;
        cnt_d       = cnt_q;
        mcand_d     = mcand_q;
        prod_d      = prod_q;
        take_alu    = accept & ~is_mul;

        if (accept && is_mul) begin
            state_d = S_MUL;
            cnt_d   = '0;
            mcand_d = op1;
            prod_d  = {{W{1'b0}}, op2};
        end

        if (state_q == S_MUL) begin
            prod_d = prod_step;
            cnt_d  = cnt_q + CW'(1);
            if (cnt_q == CW'(W - 1)) begin
                state_d     = S_IDLE;
                result_d    = prod_step[W-1:0];
                c_d         = hi_nz;
                o_d         = hi_nz;
                z_d         = ~|prod_step[W-1:0];
                s_d         = prod_step[W-1];
                out_valid_d = 1'b1;
                cq_d        = hi_nz;
            end
        end
`endif
        if (take_alu) begin
            result_d    = alu_res;
            c_d         = alu_c;
            o_d         = alu_o;
            z_d         = ~|alu_res;
            s_d         = alu_res[W-1];
            out_valid_d = 1'b1;
            cq_d        = alu_c;
        end
    end

    // State registers.
    always_ff @(posedge clk or posedge rst) begin : regs
        if (rst) begin
            result_q    <= '0;
            c_q         <= 1'b0;
            z_q         <= 1'b0;
            o_q         <= 1'b0;
            s_q         <= 1'b0;
            out_valid_q <= 1'b0;
            cq_q        <= 1'b0;
`ifdef ALU_MUL_EN
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            mcand_q     <= '0;
            prod_q      <= '0;
`endif
        end else begin
            result_q    <= result_d;
            c_q         <= c_d;
            z_q         <= z_d;
            o_q         <= o_d;
            s_q         <= s_d;
            out_valid_q <= out_valid_d;
            cq_q        <= cq_d;
`ifdef ALU_MUL_EN
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            mcand_q     <= mcand_d;
            prod_q      <= prod_d;
`endif
        end
    end

    assign result    = result_q;
    assign c_flag    = c_q;
    assign z_flag    = z_q;
    assign o_flag    = o_q;
    assign s_flag    = s_q;
    assign out_valid = out_valid_q;

endmodule

// File: tb/tb_alu_pipe_nbit.sv
// tb_alu_pipe_nbit: directed self-checking bench for alu_pipe_nbit (DWIDTH=32).
//   Inputs driven on the falling edge, outputs sampled on the falling edge.
//   Multiply checks compile in when ALU_MUL_EN is defined.
module tb_alu_pipe_nbit;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] op1, op2;
    logic [2:0]  opsel;
    logic        mode;
    logic        carry_clr;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic        c_flag, z_flag, o_flag, s_flag;
    logic        busy;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    alu_pipe_nbit #(.DWIDTH(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op1       (op1),
        .op2       (op2),
        .opsel     (opsel),
        .mode      (mode),
        .carry_clr (carry_clr),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .c_flag    (c_flag),
        .z_flag    (z_flag),
        .o_flag    (o_flag),
        .s_flag    (s_flag),
        .busy      (busy)
    );

    typedef struct {
        logic        m;
        logic [2:0]  sel;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic        c, o, z, s;
    } vec_t;

    // Present one request for a single cycle, starting at a falling edge.
    task automatic apply(input logic m, input logic [2:0] sel,
                         input logic [31:0] a, input logic [31:0] b, input logic clr);
        mode = m; opsel = sel; op1 = a; op2 = b; carry_clr = clr; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0; carry_clr = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; op1 = '0; op2 = '0; opsel = '0; mode = 1'b0;
        carry_clr = 1'b0; out_ready = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if ({out_valid, result, c_flag, z_flag, o_flag, s_flag, busy, in_ready} !== {1'b0, 32'h0, 5'b0, 1'b1}) begin
            errors++;
            $display("FAIL reset_state got ov=%b res=%h czos=%b%b%b%b busy=%b ir=%b", out_valid, result,
                     c_flag, z_flag, o_flag, s_flag, busy, in_ready);
        end
    endtask

    task automatic test_add_carry();
        apply(1'b0, 3'b000, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0);
        checks++;
        if ({out_valid, result, c_flag, z_flag, o_flag, s_flag} !== {1'b1, 32'h0, 4'b1100}) begin
            errors++;
            $display("FAIL add_wrap got ov=%b res=%h czos=%b%b%b%b exp ov=1 res=0 czos=1100", out_valid,
                     result, c_flag, z_flag, o_flag, s_flag);
        end
    endtask

    task automatic test_adc_chain();
        apply(1'b0, 3'b000, 32'hFFFF_FFFF, 32'h1, 1'b0);
        apply(1'b0, 3'b010, 32'h0, 32'h0, 1'b0);
        checks++;
        if ({out_valid, result, c_flag, z_flag} !== {1'b1, 32'h1, 2'b00}) begin
            errors++;
            $display("FAIL adc_chain got ov=%b res=%h c=%b z=%b exp 1 00000001 0 0", out_valid, result, c_flag, z_flag);
        end
        apply(1'b0, 3'b000, 32'hFFFF_FFFF, 32'h1, 1'b0);
        apply(1'b0, 3'b010, 32'h0, 32'h0, 1'b1);
        checks++;
        if ({result, c_flag, z_flag} !== {32'h0, 2'b01}) begin
            errors++;
            $display("FAIL adc_clr_same got res=%h c=%b z=%b exp 00000000 0 1", result, c_flag, z_flag);
        end
        // carry_clr on an idle cycle also wipes the stored carry
        apply(1'b0, 3'b000, 32'hFFFF_FFFF, 32'h1, 1'b0);
        carry_clr = 1'b1;
        @(negedge clk);
        carry_clr = 1'b0;
        apply(1'b0, 3'b010, 32'h0, 32'h0, 1'b0);
        checks++;
        if (result !== 32'h0) begin
            errors++;
            $display("FAIL adc_clr_idle got res=%h exp 00000000", result);
        end
    endtask

    task automatic test_sub_sra_sbb();
        apply(1'b0, 3'b001, 32'h8000_0000, 32'h0000_0001, 1'b0);
        checks++;
        if ({result, c_flag, z_flag, o_flag, s_flag} !== {32'h7FFF_FFFF, 4'b1010}) begin
            errors++;
            $display("FAIL sub_ovf got res=%h czos=%b%b%b%b exp 7fffffff 1010", result, c_flag, z_flag, o_flag, s_flag);
        end
        apply(1'b1, 3'b110, 32'h8000_0001, 32'h0, 1'b0);
        checks++;
        if ({result, c_flag, z_flag, o_flag, s_flag} !== {32'hC000_0000, 4'b1001}) begin
            errors++;
            $display("FAIL sra1 got res=%h czos=%b%b%b%b exp c0000000 1001", result, c_flag, z_flag, o_flag, s_flag);
        end
        // cq=1 from SRA1: 5-3 borrow-free
        apply(1'b0, 3'b011, 32'd5, 32'd3, 1'b0);
        checks++;
        if ({result, c_flag} !== {32'd2, 1'b1}) begin
            errors++;
            $display("FAIL sbb_cq1 got res=%h c=%b exp 00000002 1", result, c_flag);
        end
        apply(1'b0, 3'b011, 32'd3, 32'd5, 1'b0);
        checks++;
        if ({result, c_flag, s_flag} !== {32'hFFFF_FFFE, 2'b01}) begin
            errors++;
            $display("FAIL sbb_borrow got res=%h c=%b s=%b exp fffffffe 0 1", result, c_flag, s_flag);
        end
        // cq=0 now, so 5-3-1
        apply(1'b0, 3'b011, 32'd5, 32'd3, 1'b0);
        checks++;
        if ({result, c_flag} !== {32'd1, 1'b1}) begin
            errors++;
            $display("FAIL sbb_cq0 got res=%h c=%b exp 00000001 1", result, c_flag);
        end
    endtask

    task automatic test_op_vectors();
        vec_t v [16];
        v = '{
            '{1'b0, 3'b100, 32'h7FFF_FFFF, 32'h0,         32'h8000_0000, 1'b0, 1'b1, 1'b0, 1'b1},
            '{1'b0, 3'b101, 32'h0,         32'h0,         32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0, 1'b1},
            '{1'b0, 3'b101, 32'h1,         32'h0,         32'h0,         1'b1, 1'b0, 1'b1, 1'b0},
            '{1'b0, 3'b111, 32'h1,         32'h0,         32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0, 1'b1},
            '{1'b0, 3'b111, 32'h0,         32'h0,         32'h0,         1'b1, 1'b0, 1'b1, 1'b0},
            '{1'b0, 3'b111, 32'h8000_0000, 32'h0,         32'h8000_0000, 1'b0, 1'b1, 1'b0, 1'b1},
            '{1'b0, 3'b110, 32'hDEAD_BEEF, 32'h1234_5678, 32'hDEAD_BEEF, 1'b0, 1'b0, 1'b0, 1'b1},
            '{1'b0, 3'b000, 32'h7FFF_FFFF, 32'h1,         32'h8000_0000, 1'b0, 1'b1, 1'b0, 1'b1},
            '{1'b1, 3'b000, 32'hF0F0_1234, 32'h0FF0_FFFF, 32'h00F0_1234, 1'b0, 1'b0, 1'b0, 1'b0},
            '{1'b1, 3'b000, 32'hFFFF_FFFF, 32'h0,         32'h0,         1'b0, 1'b0, 1'b1, 1'b0},
            '{1'b1, 3'b001, 32'h0F00_0000, 32'h0000_00F0, 32'h0F00_00F0, 1'b0, 1'b0, 1'b0, 1'b0},
            '{1'b1, 3'b010, 32'hA5A5_A5A5, 32'hFFFF_0000, 32'h5A5A_A5A5, 1'b0, 1'b0, 1'b0, 1'b0},
            '{1'b1, 3'b011, 32'h0,         32'h0,         32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0, 1'b1},
            '{1'b1, 3'b100, 32'h8000_0001, 32'h0,         32'h0000_0002, 1'b1, 1'b0, 1'b0, 1'b0},
            '{1'b1, 3'b101, 32'h0000_0003, 32'h0,         32'h0000_0001, 1'b1, 1'b0, 1'b0, 1'b0},
            '{1'b1, 3'b101, 32'h8000_0000, 32'h0,         32'h4000_0000, 1'b0, 1'b0, 1'b0, 1'b0}
        };
        for (int i = 0; i < 16; i++) begin
            apply(v[i].m, v[i].sel, v[i].a, v[i].b, 1'b0);
            checks++;
            if ({out_valid, result, c_flag, o_flag, z_flag, s_flag} !== {1'b1, v[i].res, v[i].c, v[i].o, v[i].z, v[i].s}) begin
                errors++;
                $display("FAIL vec%0d m=%b sel=%b got ov=%b res=%h cozs=%b%b%b%b exp res=%h cozs=%b%b%b%b", i, v[i].m,
                         v[i].sel, out_valid, result, c_flag, o_flag, z_flag, s_flag, v[i].res, v[i].c, v[i].o,
                         v[i].z, v[i].s);
            end
        end
    endtask

    task automatic test_backpressure();
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        apply(1'b0, 3'b000, 32'd1, 32'd2, 1'b0);
        // second request waits while the first result is stalled
        mode = 1'b0; opsel = 3'b000; op1 = 32'd10; op2 = 32'd20; in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if ({out_valid, result, c_flag, z_flag, in_ready} !== {1'b1, 32'd3, 3'b000}) begin
                errors++;
                $display("FAIL stall%0d got ov=%b res=%h c=%b z=%b ir=%b exp 1 00000003 0 0 0", i, out_valid,
                         result, c_flag, z_flag, in_ready);
            end
            @(negedge clk);
        end
        checks++;
        if ({out_valid, result} !== {1'b1, 32'd3}) begin
            errors++;
            $display("FAIL stall_end got ov=%b res=%h exp 1 00000003", out_valid, result);
        end
        out_ready = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL stall_release_ready got %b exp 1", in_ready);
        end
        @(negedge clk);
        in_valid = 1'b0;
        checks++;
        if ({out_valid, result} !== {1'b1, 32'd30}) begin
            errors++;
            $display("FAIL stall_next_op got ov=%b res=%h exp 1 0000001e", out_valid, result);
        end
        @(negedge clk);
        checks++;
        if ({out_valid, result} !== {1'b0, 32'd30}) begin
            errors++;
            $display("FAIL drain_no_dup got ov=%b res=%h exp 0 0000001e", out_valid, result);
        end
    endtask

`ifdef ALU_MUL_EN
    task automatic test_mul();
        int n;
        apply(1'b1, 3'b111, 32'h0001_0000, 32'h0001_0000, 1'b0);
        checks++;
        if ({busy, out_valid, in_ready} !== 3'b100) begin
            errors++;
            $display("FAIL mul_busy got busy=%b ov=%b ir=%b exp 1 0 0", busy, out_valid, in_ready);
        end
        n = 1;
        while (!out_valid && n < 40) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n !== 33) begin
            errors++;
            $display("FAIL mul_latency got %0d exp 33", n);
        end
        checks++;
        if ({result, c_flag, o_flag, z_flag, busy} !== {32'h0, 4'b1110}) begin
            errors++;
            $display("FAIL mul_hi got res=%h c=%b o=%b z=%b busy=%b exp 0 1 1 1 0", result, c_flag, o_flag, z_flag, busy);
        end
        apply(1'b1, 3'b111, 32'd7, 32'd6, 1'b0);
        n = 1;
        while (!out_valid && n < 40) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if ({n, result, c_flag, o_flag, z_flag} !== {32'd33, 32'd42, 3'b000}) begin
            errors++;
            $display("FAIL mul_7x6 got n=%0d res=%h c=%b o=%b z=%b exp 33 0000002a 0 0 0", n, result, c_flag,
                     o_flag, z_flag);
        end
    endtask

    task automatic test_reset_mid_op();
        apply(1'b1, 3'b111, 32'd3, 32'd5, 1'b0);
        repeat (9) @(negedge clk);
        rst = 1'b1;
        #1;
        checks++;
        if ({out_valid, busy, result} !== {2'b00, 32'h0}) begin
            errors++;
            $display("FAIL rst_mid_mul got ov=%b busy=%b res=%h exp 0 0 0", out_valid, busy, result);
        end
        @(negedge clk);
        rst = 1'b0;
        #1;
        checks++;
        if ({in_ready, busy} !== 2'b10) begin
            errors++;
            $display("FAIL rst_release got ir=%b busy=%b exp 1 0", in_ready, busy);
        end
        repeat (35) @(negedge clk);
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL rst_no_emit got ov=%b exp 0", out_valid);
        end
    endtask
`else
    task automatic test_nor();
        apply(1'b1, 3'b111, 32'h0, 32'h0, 1'b0);
        checks++;
        if ({out_valid, result, s_flag, c_flag, o_flag, busy} !== {1'b1, 32'hFFFF_FFFF, 4'b1000}) begin
            errors++;
            $display("FAIL nor_op got ov=%b res=%h s=%b c=%b o=%b busy=%b exp 1 ffffffff 1 0 0 0", out_valid,
                     result, s_flag, c_flag, o_flag, busy);
        end
    endtask

    task automatic test_reset_mid_op();
        out_ready = 1'b0;
        apply(1'b0, 3'b000, 32'd1, 32'd2, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        checks++;
        if ({out_valid, result, busy} !== {1'b0, 32'h0, 1'b0}) begin
            errors++;
            $display("FAIL rst_pending got ov=%b res=%h busy=%b exp 0 0 0", out_valid, result, busy);
        end
        @(negedge clk);
        rst = 1'b0;
        out_ready = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL rst_release got ir=%b exp 1", in_ready);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_add_carry();
        test_adc_chain();
        test_sub_sra_sbb();
        test_op_vectors();
        test_backpressure();
`ifdef ALU_MUL_EN
        test_mul();
`else
        test_nor();
`endif
        test_reset_mid_op();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
